// File: rtl/game_pkg.sv
// Shared definitions for the game input path.
// Holds command indices, repeat FSM state encoding, parameter defaults
// and a counter-width helper.
package game_pkg;

  // Command indices into the per-command vectors.
  localparam int unsigned LEFT     = 0;
  localparam int unsigned RIGHT    = 1;
  localparam int unsigned DOWN     = 2;
  localparam int unsigned ROTATE   = 3;
  localparam int unsigned NUM_CMDS = 4;

  // Parameter defaults, in clock cycles.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
  localparam int unsigned DEF_REPEAT_RATE     = 6_500_000;
  localparam int unsigned DEF_GRAVITY_PERIOD  = 40_000_000;

  // Auto-repeat FSM states.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Width of a counter spanning 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizer, debouncer and press detector for one pushbutton.
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   raw_i    asynchronous bouncing button level, high = pressed
//   level_o  debounced level
//   press_o  one-cycle pulse on each debounced 0->1 transition
module button_debounce
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; any agreeing cycle clears the count.
  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/input_ctl.sv
// Game input controller: debounces four buttons, auto-repeats left/right/down,
// generates gravity ticks and serialises all events into one-hot command pulses.
// Ports:
//   pclk                      clock, rising edge
//   rst                       synchronous active-low reset
//   btn_*_raw                 raw bouncing button levels, high = pressed
//   pause                     freezes event generation while high
//   button_left/right/down/rotate  registered single-cycle command pulses
//   gravity_tick              high with button_down when gravity contributed
module input_ctl
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int unsigned GRAVITY_PERIOD  = DEF_GRAVITY_PERIOD
) (
  input  logic pclk,
  input  logic rst,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic btn_down_raw,
  input  logic btn_rotate_raw,
  input  logic pause,
  output logic button_left,
  output logic button_right,
  output logic button_down,
  output logic button_rotate,
  output logic gravity_tick
);

  localparam int unsigned RptSpan = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW    = cnt_width(RptSpan);
  localparam int unsigned GravW   = cnt_width(GRAVITY_PERIOD);
  localparam logic [GravW-1:0] GravMax = GravW'(GRAVITY_PERIOD - 1);

  logic [NUM_CMDS-1:0] raw_c;
  logic [NUM_CMDS-1:0] level;
  logic [NUM_CMDS-1:0] press;
  logic [NUM_CMDS-1:0] rpt_evt_c;

  assign raw_c[LEFT]   = btn_left_raw;
  assign raw_c[RIGHT]  = btn_right_raw;
  assign raw_c[DOWN]   = btn_down_raw;
  assign raw_c[ROTATE] = btn_rotate_raw;

  for (genvar g = 0; g < NUM_CMDS; g++) begin : g_btn
    // Rotate never leaves IDLE, so it never auto-repeats.
    localparam bit RepeatEn = (g != ROTATE);

    rpt_state_e      state_q;
    logic [RptW-1:0] cnt_q;
    logic            hit_c;

    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (pclk),
      .rst_ni (rst),
      .raw_i  (raw_c[g]),
      .level_o(level[g]),
      .press_o(press[g])
    );

    // Repeat event when the current interval has fully elapsed with the button held.
    always_comb begin
      hit_c = 1'b0;
      if (!pause && level[g]) begin
        if (state_q == RPT_HOLD && cnt_q == RptW'(REPEAT_DELAY - 1)) begin
          hit_c = 1'b1;
        end
        if (state_q == RPT_REPEAT && cnt_q == RptW'(REPEAT_RATE - 1)) begin
          hit_c = 1'b1;
        end
      end
    end

    // Auto-repeat FSM; pause parks it in IDLE like reset does.
    always_ff @(posedge pclk) begin
      if (!rst || pause) begin
        state_q <= RPT_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            cnt_q <= '0;
            if (press[g] && RepeatEn) begin
              state_q <= RPT_HOLD;
            end
          end
          RPT_HOLD, RPT_REPEAT: begin
            if (!level[g]) begin
              state_q <= RPT_IDLE;
              cnt_q   <= '0;
            end else if (hit_c) begin
              state_q <= RPT_REPEAT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + RptW'(1);
            end
          end
          default: begin
            state_q <= RPT_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign rpt_evt_c[g] = hit_c;
  end

  logic [GravW-1:0]    grav_cnt_q, grav_cnt_d;
  logic [NUM_CMDS-1:0] pend_q, pend_d;
  logic                grav_pend_q, grav_pend_d;
  logic [NUM_CMDS-1:0] cmd_q, cmd_d;
  logic                gtick_q, gtick_d;
  logic [NUM_CMDS-1:0] evt_c, want_c;
  logic                down_btn_c, grav_evt_c, grav_want_c;

  // Event merge, fixed-priority issue and gravity counter next state.
  always_comb begin
    down_btn_c  = !pause && (press[DOWN] || rpt_evt_c[DOWN]);
    grav_evt_c  = !pause && (grav_cnt_q == GravMax);

    evt_c         = '0;
    evt_c[LEFT]   = !pause && (press[LEFT] || rpt_evt_c[LEFT]);
    evt_c[RIGHT]  = !pause && (press[RIGHT] || rpt_evt_c[RIGHT]);
    evt_c[DOWN]   = down_btn_c || grav_evt_c;
    evt_c[ROTATE] = !pause && press[ROTATE];

    // A new event on an already-pending command simply merges into the flag.
    want_c      = pend_q | evt_c;
    grav_want_c = grav_pend_q || grav_evt_c;

    cmd_d = '0;
    if (want_c[LEFT]) begin
      cmd_d[LEFT] = 1'b1;
    end else if (want_c[RIGHT]) begin
      cmd_d[RIGHT] = 1'b1;
    end else if (want_c[DOWN]) begin
      cmd_d[DOWN] = 1'b1;
    end else if (want_c[ROTATE]) begin
      cmd_d[ROTATE] = 1'b1;
    end

    pend_d      = want_c & ~cmd_d;
    grav_pend_d = grav_want_c && !cmd_d[DOWN];
    gtick_d     = cmd_d[DOWN] && grav_want_c;

    grav_cnt_d = grav_cnt_q;
    if (down_btn_c || grav_evt_c) begin
      grav_cnt_d = '0;
    end else if (!pause) begin
      grav_cnt_d = grav_cnt_q + GravW'(1);
    end

    if (pause) begin
      pend_d      = '0;
      grav_pend_d = 1'b0;
      cmd_d       = '0;
      gtick_d     = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      grav_cnt_q  <= '0;
      pend_q      <= '0;
      grav_pend_q <= 1'b0;
      cmd_q       <= '0;
      gtick_q     <= 1'b0;
    end else begin
      grav_cnt_q  <= grav_cnt_d;
      pend_q      <= pend_d;
      grav_pend_q <= grav_pend_d;
      cmd_q       <= cmd_d;
      gtick_q     <= gtick_d;
    end
  end

  assign button_left   = cmd_q[LEFT];
  assign button_right  = cmd_q[RIGHT];
  assign button_down   = cmd_q[DOWN];
  assign button_rotate = cmd_q[ROTATE];
  assign gravity_tick  = gtick_q;

endmodule

// File: tb/tb_input_ctl.sv
// Scoreboard bench for input_ctl with short debounce/repeat/gravity periods.
module tb_input_ctl;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RR  = 3;
  localparam int unsigned GP  = 20;

  // Output vector order: {gravity_tick, rotate, down, right, left}
  localparam logic [4:0] V_L   = 5'b00001;
  localparam logic [4:0] V_R   = 5'b00010;
  localparam logic [4:0] V_D   = 5'b00100;
  localparam logic [4:0] V_ROT = 5'b01000;
  localparam logic [4:0] V_DG  = 5'b10100;

  logic pclk = 1'b0;
  logic rst = 1'b0;
  logic btn_left_raw = 1'b0, btn_right_raw = 1'b0, btn_down_raw = 1'b0, btn_rotate_raw = 1'b0;
  logic pause = 1'b0;
  logic button_left, button_right, button_down, button_rotate, gravity_tick;

  input_ctl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .GRAVITY_PERIOD (GP)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .btn_left_raw  (btn_left_raw),
    .btn_right_raw (btn_right_raw),
    .btn_down_raw  (btn_down_raw),
    .btn_rotate_raw(btn_rotate_raw),
    .pause         (pause),
    .button_left   (button_left),
    .button_right  (button_right),
    .button_down   (button_down),
    .button_rotate (button_rotate),
    .gravity_tick  (gravity_tick)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   base = 0;
  exp_t mon_e;
  logic [4:0] mon_v;

  function automatic logic [4:0] out_vec();
    return {gravity_tick, button_rotate, button_down, button_right, button_left};
  endfunction

  // Monitor: every non-idle output cycle is matched against the next expected pulse.
  always @(negedge pclk) begin
    mon_v = out_vec();
    if (mon_v != 5'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b expected none", cyc - base, mon_v);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.vec != mon_v) begin
          errors++;
          $display("FAIL pulse got cyc=%0d vec=%b expected cyc=%0d vec=%b",
                   cyc - base, mon_v, mon_e.cyc - base, mon_e.vec);
        end
      end
    end
  end

  task automatic expect_at(input int off, input logic [4:0] v);
    exp_t e;
    e.cyc = base + off;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Move to just after edge base+off.
  task automatic goto_cyc(input int off);
    if (base + off > cyc) step(base + off - cyc);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_pulses got=%0d pending expected=0 (first at cyc=%0d vec=%b)",
               name, exp_q.size(), exp_q[0].cyc - base, exp_q[0].vec);
      exp_q.delete();
    end
  endtask

  // Two reset edges; outputs must be zero after the first. base = last reset edge.
  task automatic do_reset(input string name);
    rst = 1'b0;
    step(1);
    checks++;
    if (out_vec() != 5'b0) begin
      errors++;
      $display("FAIL %s reset_outputs got=%b expected=00000", name, out_vec());
    end
    step(1);
    rst  = 1'b1;
    base = cyc;
  endtask

  task automatic end_test(input string name, input int len);
    goto_cyc(len);
    @(negedge pclk);
    #1;
    check_drained(name);
    btn_left_raw   = 1'b0;
    btn_right_raw  = 1'b0;
    btn_down_raw   = 1'b0;
    btn_rotate_raw = 1'b0;
    pause          = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Bouncing left, then steady high from +12: one pulse 7 cycles later.
    do_reset("bounce");
    expect_at(19, V_L);
    expect_at(20, V_DG);
    for (int k = 0; k < 3; k++) begin
      goto_cyc(4 * k);
      btn_left_raw = 1'b1;
      goto_cyc(4 * k + 2);
      btn_left_raw = 1'b0;
    end
    goto_cyc(12);
    btn_left_raw = 1'b1;
    goto_cyc(19);
    btn_left_raw = 1'b0;
    end_test("bounce", 30);

    // Right held 30 cycles: press, +10, then every 3; gravity deferred one cycle on a clash.
    do_reset("repeat");
    expect_at(7, V_R);
    expect_at(17, V_R);
    expect_at(20, V_R);
    expect_at(21, V_DG);
    expect_at(23, V_R);
    expect_at(26, V_R);
    expect_at(29, V_R);
    expect_at(32, V_R);
    expect_at(35, V_R);
    expect_at(40, V_DG);
    btn_right_raw = 1'b1;
    goto_cyc(30);
    btn_right_raw = 1'b0;
    end_test("repeat", 45);

    // Left and rotate pressed together.
    do_reset("left_rot");
    expect_at(7, V_L);
    expect_at(8, V_ROT);
    expect_at(20, V_DG);
    btn_left_raw   = 1'b1;
    btn_rotate_raw = 1'b1;
    goto_cyc(8);
    btn_left_raw   = 1'b0;
    btn_rotate_raw = 1'b0;
    end_test("left_rot", 25);

    // Left and right held together.
    do_reset("left_right");
    expect_at(7, V_L);
    expect_at(8, V_R);
    expect_at(20, V_DG);
    btn_left_raw  = 1'b1;
    btn_right_raw = 1'b1;
    goto_cyc(8);
    btn_left_raw  = 1'b0;
    btn_right_raw = 1'b0;
    end_test("left_right", 25);

    // Gravity every 20; down press event at counter value 15 restarts the period.
    do_reset("gravity");
    expect_at(20, V_DG);
    expect_at(40, V_DG);
    expect_at(56, V_D);
    expect_at(76, V_DG);
    goto_cyc(49);
    btn_down_raw = 1'b1;
    goto_cyc(53);
    btn_down_raw = 1'b0;
    end_test("gravity", 80);

    // Rotate held across pause; left press completing during pause is dropped;
    // gravity counter frozen for the 5 paused cycles.
    do_reset("pause");
    expect_at(7, V_ROT);
    expect_at(25, V_DG);
    btn_rotate_raw = 1'b1;
    goto_cyc(8);
    btn_left_raw = 1'b1;
    goto_cyc(10);
    pause = 1'b1;
    goto_cyc(15);
    pause = 1'b0;
    end_test("pause", 35);

    // Reset during left REPEAT, left held throughout.
    do_reset("rst_mid");
    expect_at(7, V_L);
    expect_at(17, V_L);
    expect_at(20, V_L);
    expect_at(21, V_DG);
    btn_left_raw = 1'b1;
    goto_cyc(22);
    check_drained("rst_mid_pre");
    do_reset("rst_mid");
    expect_at(7, V_L);
    expect_at(20, V_DG);
    goto_cyc(8);
    btn_left_raw = 1'b0;
    end_test("rst_mid_post", 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_ctl.md
INPUT_CTL -- requirements
Module: input_ctl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles required to accept a raw level change.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25_000_000, cycles from accepted press to first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_RATE, default 6_500_000, cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have parameter GRAVITY_PERIOD, default 40_000_000, cycles between gravity ticks.
REQ-005 SHALL have port pclk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port btn_left_raw, btn_right_raw, btn_down_raw, btn_rotate_raw  input  1 each  asynchronous, bouncing pushbutton levels, high = pressed.
REQ-008 SHALL have port pause  input  1  freezes all event generation while high.
REQ-009 SHALL have port button_left, button_right, button_down, button_rotate  output  1 each  single-cycle command pulses to game control.
REQ-010 SHALL have port gravity_tick  output  1  single-cycle pulse, high in the same cycle as a gravity-caused button_down.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-013 A press event SHALL be raised for exactly one cycle on each 0->1 transition of a debounced level; release raises no event.
REQ-014 Left, right, down SHALL each run a repeat FSM: IDLE -> (press) HOLD; HOLD -> (REPEAT_DELAY cycles elapsed, still held) REPEAT with one repeat event; REPEAT -> one repeat event every REPEAT_RATE cycles; any state -> IDLE on debounced release.
REQ-015 Rotate SHALL NOT auto-repeat; one event per press.
REQ-016 Gravity counter SHALL free-run 0..GRAVITY_PERIOD-1 and raise a gravity event on wrap; any down press/repeat event SHALL reset it to 0.
REQ-017 Each event SHALL set a per-command pending flag (left, right, down, rotate); down pending is set by down press/repeat or gravity.
REQ-018 At most one command output SHALL be high per cycle; pending flags served in priority left > right > down > rotate, served flag cleared in the issuing cycle.
REQ-019 An event arriving for a command whose flag is already pending SHALL be merged (no second pulse).
REQ-020 Output pulses SHALL be registered: event in cycle N -> pulse earliest in cycle N+1 if highest-priority pending.
REQ-021 gravity_tick SHALL be high only when button_down issues and that pending flag originated (solely or partly) from gravity.
REQ-022 While pause is high: all outputs 0, pending flags cleared, repeat FSMs forced to IDLE, gravity counter held; debouncers keep running; a button held across pause release SHALL NOT generate a press event.
REQ-023 Left and right held simultaneously SHALL both generate events; served in consecutive cycles per REQ-018.
REQ-024 Counter widths SHALL be derived by $clog2 of the corresponding parameter; no wrap other than REQ-016.

Reset
REQ-025 With rst low at a clock edge: all outputs 0, synchronizers, debounced levels, counters, pending flags 0, repeat FSMs IDLE, gravity counter 0.
REQ-026 Reset asserted mid-debounce or mid-repeat SHALL abort it; a button still held after reset release SHALL produce a press only after a full DEBOUNCE_CYCLES window.

Structure
REQ-027 Shared package game_pkg SHALL hold command index constants (LEFT=0, RIGHT=1, DOWN=2, ROTATE=3), repeat FSM state encoding, and parameter defaults.
REQ-028 Synchronizer plus debouncer plus edge detect SHALL be sub-module button_debounce, instantiated four times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, GRAVITY_PERIOD=20)
REQ-029 Raw left toggling every 2 cycles for 12 cycles, then steady high -> exactly one button_left pulse, 7 cycles after steady high begins (2 sync + 4 debounce + 1 output).
REQ-030 Right held 30 cycles -> pulses at press, press+10, then every 3 cycles until release; none after release.
REQ-031 Left and rotate pressed in the same cycle -> button_left in cycle N, button_rotate in N+1, never both high.
REQ-032 No buttons, pause low -> button_down and gravity_tick together every 20 cycles; down press at cycle 15 restarts gravity so next tick is 20 cycles after that press event.
REQ-033 Rotate held, pause asserted 5 cycles then released -> no outputs during pause, no rotate pulse after release.
REQ-034 rst driven low during left REPEAT state -> all outputs 0 next cycle; left held throughout -> next button_left 7 cycles after rst returns high.
